key_debouncer: RTL and testbench



---
 rtl/key_debouncer.sv | 143 ++++++++++++++
 tb/tb_key_debouncer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// key_debouncer: synchronises, debounces and classifies the active-low DE board pushbuttons.
// Ports: CLOCK_50/reset (async, active-high); KEY raw active-low buttons; key_level debounced
// pressed level; press_pulse/release_pulse/long_pulse one-cycle events; long_held level after long press.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] long_held
);

  typedef enum logic [2:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  // Terminal counts: a wait state accepts on the sample where cnt reaches the last value.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             held_q;

    // Two-flop synchroniser; resets to the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= KEY[g];
        sync2_q <= sync1_q;
      end
    end

    assign s = ~sync2_q;  // 1 = pressed

    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        state_q   <= ST_RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        // Pulses are high only in the cycle after the transition that sets them.
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          ST_RELEASED: begin
            if (s) begin
              state_q <= ST_PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_PRESS_WAIT: begin
            if (!s) begin
              // Glitch: drop back silently.
              state_q <= ST_RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= ST_PRESSED;
              level_q <= 1'b1;
              press_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            if (!s) begin
              state_q <= ST_RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end else if (cnt_q == LONG_LAST) begin
              state_q <= ST_HELD;
              long_q  <= 1'b1;
              held_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_HELD: begin
            if (!s) begin
              state_q <= ST_RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_RELEASE_WAIT: begin
            if (s) begin
              // Release bounce: a long press already reported stays reported;
              // otherwise the long-press timing starts over.
              state_q <= held_q ? ST_HELD : ST_PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q   <= ST_RELEASED;
              level_q   <= 1'b0;
              held_q    <= 1'b0;
              release_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign key_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign long_pulse[g]    = long_q;
    assign long_held[g]     = held_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus random key activity against a run-length reference model.
// Ports: none; drives CLOCK_50, reset and KEY of key_debouncer and observes all five outputs.
module tb_key_debouncer;
  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [NK-1:0] KEY      = '1;
  logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse, long_held;

  int checks = 0;
  int errors = 0;

  key_debouncer #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(8)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY),
    .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .long_held(long_held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: the key is seen two samples late; the level flips once
  // DEB consecutive samples disagree with it; a long press is reported after
  // LONG consecutive pressed samples following the press (or a rejected release bounce).
  logic [NK-1:0] m_h1, m_h2, m_lvl, m_held, m_press, m_rel, m_long;
  int m_mism[NK];
  int m_since[NK];
  int n_press[NK];
  int n_rel[NK];
  int n_long[NK];

  task automatic model_reset();
    m_h1 = '1; m_h2 = '1; m_lvl = '0; m_held = '0;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int j = 0; j < NK; j++) begin
      m_mism[j] = 0; m_since[j] = 0;
    end
  endtask

  task automatic model_step(input logic [NK-1:0] k);
    logic s;
    int   prev;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int j = 0; j < NK; j++) begin
      s    = ~m_h2[j];
      prev = m_mism[j];
      m_mism[j] = (s != m_lvl[j]) ? prev + 1 : 0;
      if (m_mism[j] == DEB) begin
        m_lvl[j]  = s;
        m_mism[j] = 0;
        if (s) begin
          m_press[j] = 1'b1;
          m_since[j] = 0;
        end else begin
          m_rel[j]  = 1'b1;
          m_held[j] = 1'b0;
        end
      end else if (m_lvl[j] && s) begin
        if (prev > 0) m_since[j] = 0;
        else begin
          m_since[j]++;
          if (m_since[j] == LONG && !m_held[j]) begin
            m_long[j] = 1'b1;
            m_held[j] = 1'b1;
          end
        end
      end
    end
    m_h2 = m_h1;
    m_h1 = k;
  endtask

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int j = 0; j < NK; j++) begin
      n_press[j] = 0; n_rel[j] = 0; n_long[j] = 0;
    end
  endtask

  // One clock: drive KEY on the falling edge, sample just after the rising edge.
  task automatic tick(input logic [NK-1:0] k);
    @(negedge CLOCK_50);
    KEY = k;
    @(posedge CLOCK_50);
    #1;
    model_step(k);
    chk("key_level", key_level, m_lvl);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("long_pulse", long_pulse, m_long);
    chk("long_held", long_held, m_held);
    for (int j = 0; j < NK; j++) begin
      n_press[j] += int'(press_pulse[j]);
      n_rel[j]   += int'(release_pulse[j]);
      n_long[j]  += int'(long_pulse[j]);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, key_level, '0);
    chk({tag, "_press"}, press_pulse, '0);
    chk({tag, "_release"}, release_pulse, '0);
    chk({tag, "_long"}, long_pulse, '0);
    chk({tag, "_held"}, long_held, '0);
  endtask

  logic [NK-1:0] rnd_lvl;
  int            rnd_rem[NK];

  initial begin
    model_reset();
    clear_counts();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_all_zero("reset");
    @(posedge CLOCK_50);
    #3 reset = 1'b0;

    // Clean press/release on key 0.
    for (int i = 0; i < 30; i++) begin
      tick(4'b1110);
      if (i == 4)  chk("clean_press_early", press_pulse, 4'b0000);
      if (i == 5)  chk("clean_press_edge6", press_pulse, 4'b0001);
      if (i == 25) chk("clean_long_edge26", long_pulse, 4'b0001);
      if (i == 29) chk("clean_held", long_held, 4'b0001);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111);
      if (i == 5) chk("clean_release_edge6", release_pulse, 4'b0001);
    end
    chk_int("clean_n_press0", n_press[0], 1);
    chk_int("clean_n_long0", n_long[0], 1);
    chk_int("clean_n_rel0", n_rel[0], 1);

    // Press bounce on key 1, then a stable press released before long.
    clear_counts();
    for (int i = 0; i < 12; i++) tick(((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111);
    chk_int("bounce_no_press", n_press[1], 0);
    for (int i = 0; i < 20; i++) begin
      tick(4'b1101);
      if (i == 5) chk("bounce_press_edge6", press_pulse, 4'b0010);
    end
    for (int i = 0; i < 10; i++) tick(4'b1111);
    chk_int("bounce_n_press1", n_press[1], 1);
    chk_int("bounce_n_long1", n_long[1], 0);

    // Short press on key 2.
    clear_counts();
    for (int i = 0; i < 10; i++) tick(4'b1011);
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111);
      if (i == 5) chk("short_release_edge6", release_pulse, 4'b0100);
    end
    chk_int("short_n_press2", n_press[2], 1);
    chk_int("short_n_long2", n_long[2], 0);

    // Release bounce on key 3 while HELD.
    clear_counts();
    for (int i = 0; i < 30; i++) tick(4'b0111);
    for (int i = 0; i < 2; i++) tick(4'b1111);
    for (int i = 0; i < 10; i++) tick(4'b0111);
    chk("glitch_held3", long_held, 4'b1000);
    chk_int("glitch_no_release", n_rel[3], 0);
    for (int i = 0; i < 10; i++) tick(4'b1111);
    chk_int("glitch_n_long3", n_long[3], 1);
    chk_int("glitch_n_rel3", n_rel[3], 1);

    // Simultaneous press on keys 0 and 3.
    for (int i = 0; i < 8; i++) begin
      tick(4'b0110);
      if (i == 5) chk("simul_press", press_pulse, 4'b1001);
    end
    for (int i = 0; i < 10; i++) tick(4'b1111);

    // Reset while key 0 is held down.
    clear_counts();
    for (int i = 0; i < 10; i++) tick(4'b1110);
    chk("pre_reset_level", key_level, 4'b0001);
    #3 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #3 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b1110);
      if (i == 5) chk("post_reset_press", press_pulse, 4'b0001);
    end
    chk_int("reset_no_release", n_rel[0], 0);
    for (int i = 0; i < 10; i++) tick(4'b1111);

    // Random per-key activity: runs of 1..30 cycles mix bounces, short and long presses.
    rnd_lvl = '1;
    for (int j = 0; j < NK; j++) rnd_rem[j] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int j = 0; j < NK; j++) begin
        if (rnd_rem[j] == 0) begin
          rnd_lvl[j] = ~rnd_lvl[j];
          rnd_rem[j] = int'($urandom_range(1, 30));
        end
        rnd_rem[j]--;
      end
      tick(rnd_lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
